mmio_button_bridge: RTL and testbench

- Parametrised memory-mapped I/O bridge between the processor data-memory port, the RAM, N push-buttons and the VGA controller.
- Each button channel has a synchroniser, a debouncer and a sticky press-event flag that is cleared when the processor reads it.
- Reads of channel addresses return button status; writes to the output address are latched for the VGA controller. All other accesses pass through to RAM data.
- Sits between processor, RAM and VGAController in the top-level wrapper. It replaces ad-hoc per-button address decode and raw level sampling.

---
 rtl/mmio_pkg.sv | 27 ++
 rtl/btn_debounce_channel.sv | 61 ++++++
 rtl/mmio_button_bridge.sv | 119 +++++++++++
 tb/tb_mmio_button_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the MMIO button bridge.
package mmio_pkg;

   // Default word addresses of the memory-mapped registers
   localparam int unsigned DEFAULT_OUT_ADDR  = 32'd2000;
   localparam int unsigned DEFAULT_BASE_ADDR = 32'd3000;
   localparam int unsigned DEFAULT_STRIDE    = 32'd1000;

   // Bit positions inside a channel status read word
   localparam int ST_PENDING = 0;
   localparam int ST_LEVEL   = 1;

   // Number of bits needed to hold values 0 .. v-1 (at least 1)
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and
// rising-edge detect. rise_pulse is high during the cycle whose closing
// edge moves level from 0 to 1, so a consumer register sees it on that edge.
module btn_debounce_channel
   import mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
)(
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int             CW      = clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_change;
   logic          w_accept;

   assign w_change   = (r_s2 != r_level);
   assign w_accept   = w_change && (r_cnt == CNT_MAX);
   assign rise_pulse = w_accept && r_s2;
   assign level      = r_level;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (!w_change) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_level <= r_s2;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mmio_button_bridge.sv
// Memory-mapped bridge: button status registers with read-to-clear press
// flags, a write-only VGA output register, and RAM pass-through for all
// other addresses. Read data is registered (one cycle latency).
module mmio_button_bridge
   import mmio_pkg::*;
#(
   parameter int          NUM_BTNS        = 4,
   parameter int unsigned BASE_ADDR       = DEFAULT_BASE_ADDR,
   parameter int unsigned STRIDE          = DEFAULT_STRIDE,
   parameter int unsigned OUT_ADDR        = DEFAULT_OUT_ADDR,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          DATA_W          = 32
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   input  logic [31:0]         address_dmem,
   input  logic                wren,
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W-1:0]   q_ram,
   output logic [DATA_W-1:0]   q_dmem,
   output logic [DATA_W-1:0]   to_vga,
   output logic                to_vga_valid,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_pending
);

   if (NUM_BTNS < 1 || NUM_BTNS > 16) begin : g_bad_num
      $error("NUM_BTNS must be in 1..16");
   end
   if (DATA_W < 2) begin : g_bad_width
      $error("DATA_W must hold the two status bits");
   end

   logic [NUM_BTNS-1:0] w_level;
   logic [NUM_BTNS-1:0] w_rise;
   logic [NUM_BTNS-1:0] w_hit;
   logic [NUM_BTNS-1:0] w_clr;
   logic                w_out_hit;
   logic [DATA_W-1:0]   w_rd_word;

   logic [NUM_BTNS-1:0] r_pending;
   logic [DATA_W-1:0]   r_q_dmem;
   logic [DATA_W-1:0]   r_to_vga;
   logic                r_vga_valid;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      localparam logic [31:0] CH_ADDR = 32'(BASE_ADDR + i * STRIDE);

      if (CH_ADDR == 32'(OUT_ADDR)) begin : g_addr_clash
         $error("channel address collides with OUT_ADDR");
      end

      btn_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .raw        (btn_in[i]),
         .level      (w_level[i]),
         .rise_pulse (w_rise[i])
      );

      assign w_hit[i] = (address_dmem == CH_ADDR);
   end

   assign w_out_hit = (address_dmem == 32'(OUT_ADDR));
   assign w_clr     = w_hit & {NUM_BTNS{~wren}};

   // Select status word for a channel read, RAM data otherwise
   always_comb begin
      w_rd_word = q_ram;
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (!wren && w_hit[i]) begin
            w_rd_word             = '0;
            w_rd_word[ST_LEVEL]   = w_level[i];
            w_rd_word[ST_PENDING] = r_pending[i];
         end
      end
   end

   // Sticky press flags: a new rising event beats a same-cycle read clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_rise;
      end
   end

   // Registered read data back to the processor
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q_dmem <= '0;
      end else begin
         r_q_dmem <= w_rd_word;
      end
   end

   // Latch writes to the VGA register and pulse valid for each one
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_to_vga    <= '0;
         r_vga_valid <= 1'b0;
      end else begin
         r_vga_valid <= wren && w_out_hit;
         if (wren && w_out_hit) begin
            r_to_vga <= data;
         end
      end
   end

   assign q_dmem       = r_q_dmem;
   assign to_vga       = r_to_vga;
   assign to_vga_valid = r_vga_valid;
   assign btn_level    = w_level;
   assign btn_pending  = r_pending;

endmodule

// File: tb/tb_mmio_button_bridge.sv
// Directed bench for mmio_button_bridge with DEBOUNCE_CYCLES=4, NUM_BTNS=4.
module tb_mmio_button_bridge;

   localparam int NB = 4;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic [NB-1:0] btn_in;
   logic [31:0]   address_dmem;
   logic          wren;
   logic [DW-1:0] data;
   logic [DW-1:0] q_ram;
   logic [DW-1:0] q_dmem;
   logic [DW-1:0] to_vga;
   logic          to_vga_valid;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pending;

   int checks = 0;
   int errors = 0;

   mmio_button_bridge #(
      .NUM_BTNS        (NB),
      .DEBOUNCE_CYCLES (4),
      .DATA_W          (DW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .btn_in       (btn_in),
      .address_dmem (address_dmem),
      .wren         (wren),
      .data         (data),
      .q_ram        (q_ram),
      .q_dmem       (q_dmem),
      .to_vga       (to_vga),
      .to_vga_valid (to_vga_valid),
      .btn_level    (btn_level),
      .btn_pending  (btn_pending)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges, then settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic bus_idle();
      address_dmem = 32'd0;
      wren         = 1'b0;
      data         = '0;
      q_ram        = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL reset_q_dmem: got %h expected %h", q_dmem, 32'h0); end
      checks++; if (to_vga !== 32'h0) begin errors++; $display("FAIL reset_to_vga: got %h expected %h", to_vga, 32'h0); end
      checks++; if (to_vga_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", to_vga_valid); end
      checks++; if (btn_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b expected 0000", btn_level); end
      checks++; if (btn_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", btn_pending); end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_clean_press();
      btn_in[0] = 1'b1;
      tick(5);
      checks++; if (btn_level[0] !== 1'b0) begin errors++; $display("FAIL press_level_early: got %b expected 0", btn_level[0]); end
      checks++; if (btn_pending[0] !== 1'b0) begin errors++; $display("FAIL press_pending_early: got %b expected 0", btn_pending[0]); end
      tick(1);
      checks++; if (btn_level[0] !== 1'b1) begin errors++; $display("FAIL press_level: got %b expected 1", btn_level[0]); end
      checks++; if (btn_pending[0] !== 1'b1) begin errors++; $display("FAIL press_pending: got %b expected 1", btn_pending[0]); end
   endtask

   task automatic test_glitch();
      btn_in[2] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) btn_in[2] = 1'b0;
         tick(1);
         checks++;
         if (btn_level[2] !== 1'b0 || btn_pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_cycle%0d: got level %b pending %b expected 0 0", i, btn_level[2], btn_pending[2]);
         end
      end
   endtask

   task automatic test_read_clear();
      address_dmem = 32'd3000;
      wren = 1'b0;
      tick(1);
      checks++; if (q_dmem !== 32'h00000003) begin errors++; $display("FAIL read_clear_first: got %h expected %h", q_dmem, 32'h3); end
      checks++; if (btn_pending[0] !== 1'b0) begin errors++; $display("FAIL read_clear_pending: got %b expected 0", btn_pending[0]); end
      tick(1);
      checks++; if (q_dmem !== 32'h00000002) begin errors++; $display("FAIL read_clear_second: got %h expected %h", q_dmem, 32'h2); end
      bus_idle();
      tick(1);
   endtask

   task automatic test_simultaneous();
      btn_in[1] = 1'b1;
      tick(5);
      checks++; if (btn_level[1] !== 1'b0) begin errors++; $display("FAIL simul_level_before: got %b expected 0", btn_level[1]); end
      address_dmem = 32'd4000;
      tick(1);
      checks++; if (q_dmem !== 32'h00000000) begin errors++; $display("FAIL simul_q_dmem: got %h expected %h", q_dmem, 32'h0); end
      checks++; if (btn_pending[1] !== 1'b1) begin errors++; $display("FAIL simul_pending: got %b expected 1", btn_pending[1]); end
      checks++; if (btn_level[1] !== 1'b1) begin errors++; $display("FAIL simul_level: got %b expected 1", btn_level[1]); end
      bus_idle();
      tick(1);
   endtask

   task automatic test_vga_write();
      address_dmem = 32'd2000;
      wren = 1'b1;
      data = 32'hDEADBEEF;
      tick(1);
      checks++; if (to_vga !== 32'hDEADBEEF) begin errors++; $display("FAIL vga_data: got %h expected %h", to_vga, 32'hDEADBEEF); end
      checks++; if (to_vga_valid !== 1'b1) begin errors++; $display("FAIL vga_valid: got %b expected 1", to_vga_valid); end
      bus_idle();
      tick(1);
      checks++; if (to_vga_valid !== 1'b0) begin errors++; $display("FAIL vga_valid_drop: got %b expected 0", to_vga_valid); end
      checks++; if (to_vga !== 32'hDEADBEEF) begin errors++; $display("FAIL vga_hold: got %h expected %h", to_vga, 32'hDEADBEEF); end
      // Writes to channel addresses must not touch VGA or pending state
      address_dmem = 32'd5000;
      wren = 1'b1;
      data = 32'h11111111;
      tick(1);
      address_dmem = 32'd4000;
      data = 32'h22222222;
      tick(1);
      bus_idle();
      checks++; if (to_vga !== 32'hDEADBEEF) begin errors++; $display("FAIL chwrite_to_vga: got %h expected %h", to_vga, 32'hDEADBEEF); end
      checks++; if (to_vga_valid !== 1'b0) begin errors++; $display("FAIL chwrite_valid: got %b expected 0", to_vga_valid); end
      checks++; if (btn_pending !== 4'b0010) begin errors++; $display("FAIL chwrite_pending: got %b expected 0010", btn_pending); end
      checks++; if (btn_level !== 4'b0011) begin errors++; $display("FAIL chwrite_level: got %b expected 0011", btn_level); end
      tick(1);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [3];
      vals[0] = 32'hA5A5A5A5;
      vals[1] = 32'h0000FFFF;
      vals[2] = 32'h80000001;
      address_dmem = 32'd2000;
      wren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data = vals[i];
         tick(1);
         checks++;
         if (to_vga !== vals[i] || to_vga_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write%0d: got %h valid %b expected %h valid 1", i, to_vga, to_vga_valid, vals[i]);
         end
      end
      bus_idle();
      tick(1);
      checks++; if (to_vga_valid !== 1'b0 || to_vga !== 32'h80000001) begin errors++; $display("FAIL b2b_end: got %h valid %b expected %h valid 0", to_vga, to_vga_valid, 32'h80000001); end
   endtask

   task automatic test_pass_through();
      address_dmem = 32'd100;
      q_ram = 32'h12345678;
      tick(1);
      checks++; if (q_dmem !== 32'h12345678) begin errors++; $display("FAIL pass_read: got %h expected %h", q_dmem, 32'h12345678); end
      // A write cycle to a channel address returns RAM data and clears nothing
      address_dmem = 32'd4000;
      wren = 1'b1;
      q_ram = 32'h0000CAFE;
      tick(1);
      checks++; if (q_dmem !== 32'h0000CAFE) begin errors++; $display("FAIL pass_write_cycle: got %h expected %h", q_dmem, 32'h0000CAFE); end
      checks++; if (btn_pending[1] !== 1'b1) begin errors++; $display("FAIL pass_write_pending: got %b expected 1", btn_pending[1]); end
      bus_idle();
      tick(1);
   endtask

   task automatic test_reset_mid();
      btn_in[3] = 1'b1;
      tick(3);
      #3 reset = 1'b1;
      #1;
      checks++; if (q_dmem !== 32'h0 || to_vga !== 32'h0 || to_vga_valid !== 1'b0) begin errors++; $display("FAIL midreset_bus: got q %h vga %h valid %b expected 0 0 0", q_dmem, to_vga, to_vga_valid); end
      checks++; if (btn_level !== 4'b0000 || btn_pending !== 4'b0000) begin errors++; $display("FAIL midreset_btn: got level %b pending %b expected 0000 0000", btn_level, btn_pending); end
      tick(1);
      reset = 1'b0;
      tick(5);
      checks++; if (btn_pending[3] !== 1'b0) begin errors++; $display("FAIL rerise_early: got %b expected 0", btn_pending[3]); end
      tick(1);
      checks++; if (btn_pending[3] !== 1'b1) begin errors++; $display("FAIL rerise_pending: got %b expected 1", btn_pending[3]); end
      address_dmem = 32'd6000;
      tick(1);
      checks++; if (q_dmem !== 32'h00000003) begin errors++; $display("FAIL rerise_read: got %h expected %h", q_dmem, 32'h3); end
      bus_idle();
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checks++;
         if (btn_pending[3] !== 1'b0) begin errors++; $display("FAIL rerise_once%0d: got %b expected 0", i, btn_pending[3]); end
      end
   endtask

   // Stimulus sequence and final report
   initial begin
      reset  = 1'b0;
      btn_in = '0;
      bus_idle();
      #2;
      test_reset();
      test_clean_press();
      test_glitch();
      test_read_clear();
      test_simultaneous();
      test_vga_write();
      test_back_to_back();
      test_pass_through();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
